// File: rtl/cbm2_pkg.sv
// cbm2_pkg: shared loader state encoding and ioctl image index constants.
package cbm2_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_LO, ST_HI, ST_FILL, ST_DONE} ld_state_t;
  localparam logic [7:0] IOCTL_IDX_BOOT = 8'd0;
  localparam logic [7:0] IOCTL_IDX_CART = 8'd1;
  localparam logic [7:0] IOCTL_IDX_CHAR = 8'd2;
endpackage

// File: rtl/rom_loader.sv
// rom_loader: turns 16-bit ioctl download words into byte writes to a ROM port,
// padding the unwritten top of the ROM with FILL once the download ends.
// Ports: clock/reset (async, active high); ioctl_* download source with
// ioctl_wait backpressure; rom_addr/rom_wren with rom_data one cycle later;
// busy while loading or padding; done once the whole ROM has been written.
module rom_loader
  import cbm2_pkg::*;
#(
  parameter int         ADDRWIDTH = 14,
  parameter logic [7:0] INDEX     = IOCTL_IDX_BOOT,
  parameter logic [7:0] FILL      = 8'hFF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ioctl_download,
  input  logic [7:0]           ioctl_index,
  input  logic                 ioctl_wr,
  input  logic [24:0]          ioctl_addr,
  input  logic [15:0]          ioctl_dout,
  output logic                 ioctl_wait,
  output logic [ADDRWIDTH-1:0] rom_addr,
  output logic                 rom_wren,
  output logic [7:0]           rom_data,
  output logic                 busy,
  output logic                 done
);
  localparam int AW = ADDRWIDTH;
  localparam logic [AW:0] ROM_END = {1'b1, {AW{1'b0}}};
  ld_state_t state_q, state_d;
  logic [AW:0] ptr_q, ptr_d, hw_q, hw_d, ptr_nx, ptr_p2, in_addr;
  logic [15:0] word_q, word_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [7:0] rom_data_q, rom_data_d;
  logic rom_wren_q, rom_wren_d, wait_q, wait_d, busy_q, busy_d;
  logic done_q, done_d, got_q, got_d;
  logic idx_ok, accept, unused;
  assign unused = ioctl_addr[0];
  assign idx_ok = ioctl_download && ioctl_index == INDEX;
  assign accept = idx_ok && ioctl_wr && (state_q == ST_IDLE || state_q == ST_DONE);
  // Anything at or above the ROM size collapses to ROM_END so its top bit flags "do not write".
  assign in_addr = |ioctl_addr[24:AW] ? ROM_END : {ioctl_addr[AW:1], 1'b0};
  assign ptr_nx = ptr_q + (AW+1)'(1);
  assign ptr_p2 = ptr_q + (AW+1)'(2);
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    hw_d = hw_q;
    word_d = word_q;
    got_d = got_q;
    done_d = done_q;
    rom_addr_d = rom_addr_q;
    rom_data_d = rom_data_q;
    rom_wren_d = 1'b0;
    // Held through the first IDLE cycle so the source sees three wait cycles per word.
    wait_d = accept || state_q == ST_LO || state_q == ST_HI;
    if (accept) begin
      state_d = ST_LO;
      ptr_d = in_addr;
      word_d = ioctl_dout;
      got_d = 1'b1;
      done_d = 1'b0;
      hw_d = got_q ? hw_q : '0;
      rom_wren_d = !in_addr[AW];
      rom_addr_d = in_addr[AW-1:0];
    end else if (state_q == ST_IDLE && got_q && !ioctl_download) begin
      // Level check in IDLE lets a word in flight finish before padding starts.
      got_d = 1'b0;
      state_d = hw_q[AW] ? ST_DONE : ST_FILL;
      done_d = hw_q[AW];
      ptr_d = hw_q;
      rom_wren_d = !hw_q[AW];
      rom_addr_d = hw_q[AW-1:0];
    end else if (state_q == ST_LO) begin
      state_d = ST_HI;
      rom_wren_d = !ptr_q[AW];
      rom_addr_d = ptr_nx[AW-1:0];
      rom_data_d = word_q[7:0];
    end else if (state_q == ST_HI) begin
      state_d = ST_IDLE;
      rom_data_d = word_q[15:8];
      hw_d = (!ptr_q[AW] && ptr_p2 > hw_q) ? ptr_p2 : hw_q;
    end else if (state_q == ST_FILL) begin
      state_d = ptr_nx[AW] ? ST_DONE : ST_FILL;
      done_d = ptr_nx[AW];
      ptr_d = ptr_nx;
      rom_wren_d = !ptr_nx[AW];
      rom_addr_d = ptr_nx[AW-1:0];
      rom_data_d = FILL;
    end
    busy_d = state_d inside {ST_LO, ST_HI, ST_FILL} || (state_d == ST_IDLE && idx_ok);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q <= '0;
      hw_q <= '0;
      word_q <= '0;
      got_q <= 1'b0;
      done_q <= 1'b0;
      rom_addr_q <= '0;
      rom_data_q <= '0;
      rom_wren_q <= 1'b0;
      wait_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      hw_q <= hw_d;
      word_q <= word_d;
      got_q <= got_d;
      done_q <= done_d;
      rom_addr_q <= rom_addr_d;
      rom_data_q <= rom_data_d;
      rom_wren_q <= rom_wren_d;
      wait_q <= wait_d;
      busy_q <= busy_d;
    end
  end
  assign ioctl_wait = wait_q;
  assign rom_addr = rom_addr_q;
  assign rom_wren = rom_wren_q;
  assign rom_data = rom_data_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule
